// File: rtl/touch_adc_seq.sv
// Purpose : sequencer for an ADS7843-class resistive-touch ADC; debounces pen-down, runs paired X/Y frames,
//           averages 2^AVG_LOG2 pairs and publishes 8-bit coordinates.
// Latency : a run takes 2^(AVG_LOG2+1) * (48*CLK_DIV + 1) cycles, plus 1 PUBLISH cycle; x/y/new_coord_r are registered.
// Backpressure: none; downstream must take each one-cycle new_coord_r pulse (x/y hold until the next pulse).
// Ports   : sys_clk / iRST_n clock and async active-low reset; penirq_raw_n raw pen IRQ, penirq_n its 2-FF synced copy;
//           adc_cs_n / adc_dclk / adc_din / adc_dout ADC serial pins; x / y averaged coordinates;
//           new_coord_r update strobe; transmit_en high while a touch session is active.
module touch_adc_seq #(
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned DEBOUNCE = 1024,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned GAP      = 2048,
  parameter logic [7:0]  CMD_X    = 8'hD0,
  parameter logic [7:0]  CMD_Y    = 8'h90
) (
  input  logic       sys_clk,
  input  logic       iRST_n,
  input  logic       penirq_raw_n,
  input  logic       adc_dout,
  output logic       adc_dclk,
  output logic       adc_cs_n,
  output logic       adc_din,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       new_coord_r,
  output logic       transmit_en,
  output logic       penirq_n
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DEB_DN  = 3'd1;
  localparam logic [2:0] S_CONV_X  = 3'd2;
  localparam logic [2:0] S_CONV_Y  = 3'd3;
  localparam logic [2:0] S_PUBLISH = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0]    NPAIR    = 5'(1 << AVG_LOG2);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    div_q, div_d;
  logic [5:0]    half_q, half_d;   // dclk half-period index within a frame, 0..47
  logic [5:0]    half_nxt;
  logic [11:0]   shift_q, shift_d;
  logic [15:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [4:0]    pair_q, pair_d;
  logic          cs_n_q, cs_n_d, dclk_q, dclk_d, din_q, din_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic          new_q, new_d, te_q, te_d;
  logic [7:0]    cmd;

  always_comb begin
    sync1_d  = penirq_raw_n;
    sync2_d  = sync1_q;
    state_d  = state_q;
    deb_d    = deb_q;
    gap_d    = gap_q;
    div_d    = div_q;
    half_d   = half_q;
    half_nxt = half_q + 6'd1;
    shift_d  = shift_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    pair_d   = pair_q;
    cs_n_d   = cs_n_q;
    dclk_d   = dclk_q;
    din_d    = din_q;
    x_d      = x_q;
    y_d      = y_q;
    new_d    = 1'b0;
    te_d     = te_q;
    cmd      = (state_q == S_CONV_X) ? CMD_X : CMD_Y;

    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          deb_d   = {{(DW-1){1'b0}}, 1'b1};
          state_d = S_DEB_DN;
        end
      end
      S_DEB_DN: begin
        if (sync2_q) begin
          // a bounce throws the whole count away; IDLE restarts it on the next low
          deb_d   = '0;
          state_d = S_IDLE;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          state_d = S_CONV_X;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      S_CONV_X, S_CONV_Y: begin
        // cs_n is still high on entry: this cycle opens the frame, so frames never abut
        if (cs_n_q) begin
          cs_n_d  = 1'b0;
          div_d   = '0;
          half_d  = '0;
          dclk_d  = 1'b0;
          din_d   = cmd[7];
          shift_d = '0;
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (half_q == 6'd47) begin
            // end of the 24th high half: close the frame, dclk parks low with cs_n
            cs_n_d = 1'b1;
            dclk_d = 1'b0;
            din_d  = 1'b0;
            if (state_q == S_CONV_X) begin
              acc_x_d = acc_x_q + {4'd0, shift_q};
              state_d = S_CONV_Y;
            end else begin
              acc_y_d = acc_y_q + {4'd0, shift_q};
              pair_d  = pair_q + 5'd1;
              state_d = (pair_q + 5'd1 == NPAIR) ? S_PUBLISH : S_CONV_X;
            end
          end else begin
            half_d = half_nxt;
            dclk_d = half_nxt[0];
            // bit k is presented in halves 2k/2k+1, i.e. set up while dclk is low before rising edge k
            din_d  = (half_nxt < 6'd16) ? cmd[~half_nxt[3:1]] : 1'b0;
            // rising edges 9..20 start halves 19..41 and carry D11..D0
            if (half_nxt[0] && half_nxt >= 6'd19 && half_nxt <= 6'd41) begin
              shift_d = {shift_q[10:0], adc_dout};
            end
          end
        end
      end
      S_PUBLISH: begin
        x_d     = acc_x_q[AVG_LOG2+11 : AVG_LOG2+4];
        y_d     = acc_y_q[AVG_LOG2+11 : AVG_LOG2+4];
        new_d   = 1'b1;
        te_d    = 1'b1;
        acc_x_d = '0;
        acc_y_d = '0;
        pair_d  = '0;
        gap_d   = '0;
        deb_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (sync2_q) begin
          deb_d = deb_q + 1'b1;
        end else begin
          deb_d = '0;
        end
        // pen-up wins over a simultaneous gap expiry
        if (sync2_q && deb_q == DEB_LAST) begin
          deb_d   = '0;
          state_d = S_RELEASE;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_CONV_X;
        end
      end
      S_RELEASE: begin
        te_d    = 1'b0;
        deb_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      deb_q   <= '0;
      gap_q   <= '0;
      div_q   <= '0;
      half_q  <= '0;
      shift_q <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      pair_q  <= '0;
      cs_n_q  <= 1'b1;
      dclk_q  <= 1'b0;
      din_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      new_q   <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      deb_q   <= deb_d;
      gap_q   <= gap_d;
      div_q   <= div_d;
      half_q  <= half_d;
      shift_q <= shift_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      pair_q  <= pair_d;
      cs_n_q  <= cs_n_d;
      dclk_q  <= dclk_d;
      din_q   <= din_d;
      x_q     <= x_d;
      y_q     <= y_d;
      new_q   <= new_d;
      te_q    <= te_d;
    end
  end

  assign adc_cs_n    = cs_n_q;
  assign adc_dclk    = dclk_q;
  assign adc_din     = din_q;
  assign x           = x_q;
  assign y           = y_q;
  assign new_coord_r = new_q;
  assign transmit_en = te_q;
  assign penirq_n    = sync2_q;

endmodule
